// File: rtl/activity_level_timer.sv
// Activity timer: synchronizes a step pulse, counts steps per one-second window and credits
// each SUSTAIN-second run of high seconds (up to GRACE low seconds tolerated) as one minute.
module activity_level_timer #(
    parameter int SEC_DIV = 50_000_000,
    parameter int CNT_W   = 8,
    parameter int SUSTAIN = 60,
    parameter int GRACE   = 2,
    parameter int TIME_W  = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             step,
    input  logic [CNT_W-1:0]                 threshold,
    input  logic                             clear_total,
    output logic                             sec_tick,
    output logic [CNT_W-1:0]                 steps_per_sec,
    output logic                             active,
    output logic [$clog2(SUSTAIN+1)-1:0]     streak_secs,
    output logic [TIME_W-1:0]                high_activity_min
);

    localparam int PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam int SW = $clog2(SUSTAIN + 1);
    localparam int GW = $clog2(GRACE + 2);
    localparam logic [PW-1:0] PRE_LAST = PW'(SEC_DIV - 1);
    localparam logic [SW:0]   SUST_V   = (SW + 1)'(SUSTAIN);
    localparam logic [GW-1:0] GRACE_V  = GW'(GRACE);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

    logic          sync1, sync2, prev;
    logic [2:0]    sync_vld;
    logic          step_evt;
    logic [PW-1:0] presc;
    logic [CNT_W-1:0] win_cnt, win_next;
    logic          sec_high;
    state_t        state, state_nxt;
    logic [SW-1:0] streak_nxt;
    logic [SW:0]   streak_inc;
    logic [GW-1:0] gap, gap_nxt, gap_inc;
    logic          credit;

    // The first valid synchronized sample cannot form an edge, so a level held across reset is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            sync_vld <= 3'b000;
        end else begin
            sync1    <= step;
            sync2    <= sync1;
            prev     <= sync2;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign step_evt = enable & sync_vld[2] & sync2 & ~prev;
    assign sec_tick = enable && (presc == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         presc <= '0;
        else if (sec_tick) presc <= '0;
        else if (enable)   presc <= presc + 1'b1;
    end

    assign win_next = (step_evt && (win_cnt != '1)) ? win_cnt + 1'b1 : win_cnt;
    assign sec_high = (win_next >= threshold);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt       <= '0;
            steps_per_sec <= '0;
        end else if (sec_tick) begin
            win_cnt       <= '0;
            steps_per_sec <= win_next;
        end else begin
            win_cnt       <= win_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            streak_secs <= '0;
            gap         <= '0;
        end else begin
            state       <= state_nxt;
            streak_secs <= streak_nxt;
            gap         <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak_secs;
        gap_nxt    = gap;
        credit     = 1'b0;
        streak_inc = {1'b0, streak_secs} + 1'b1;
        gap_inc    = gap + 1'b1;
        if (sec_tick) begin
            if (sec_high) begin
                // Streak is zero in IDLE, so the shared increment starts a new streak at one.
                state_nxt = ACTIVE;
                gap_nxt   = '0;
                if (streak_inc == SUST_V) begin
                    streak_nxt = '0;
                    credit     = 1'b1;
                end else begin
                    streak_nxt = streak_inc[SW-1:0];
                end
            end else begin
                case (state)
                    ACTIVE: begin
                        if (GRACE > 0) begin
                            state_nxt = PAUSE;
                            gap_nxt   = GAP_ONE;
                        end else begin
                            state_nxt  = IDLE;
                            streak_nxt = '0;
                        end
                    end
                    PAUSE: begin
                        if (gap_inc > GRACE_V) begin
                            state_nxt  = IDLE;
                            streak_nxt = '0;
                            gap_nxt    = '0;
                        end else begin
                            gap_nxt = gap_inc;
                        end
                    end
                    default: begin
                        state_nxt  = IDLE;
                        streak_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        active = (state == ACTIVE) || (state == PAUSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 high_activity_min <= '0;
        else if (clear_total)                      high_activity_min <= '0;
        else if (credit && (high_activity_min != '1)) high_activity_min <= high_activity_min + 1'b1;
    end

endmodule

// File: tb/tb_activity_level_timer.sv
// Directed bench: a behavioural model pushes expected per-second results; a monitor pops them on each tick.
module tb_activity_level_timer;

    logic       clk = 1'b0;
    logic       reset, enable, step, clear_total;
    logic [3:0] threshold;
    logic       sec_tick;
    logic [3:0] steps_per_sec;
    logic       active;
    logic [1:0] streak_secs;
    logic [3:0] high_activity_min;

    // Second instance with a long window, used only for step-count saturation.
    logic       step_b;
    logic       enable_b    = 1'b1;
    logic       clear_b     = 1'b0;
    logic [3:0] threshold_b = 4'd2;
    logic       tick_b, active_b;
    logic [3:0] spc_b, min_b;
    logic [1:0] streak_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_tick = 0;

    typedef struct {
        int spc;
        int act;
        int strk;
        int mins;
    } exp_t;
    exp_t sb[$];

    int m_state, m_streak, m_gap, m_min, m_spc;

    always #5 clk = ~clk;

    activity_level_timer #(.SEC_DIV(10), .CNT_W(4), .SUSTAIN(3), .GRACE(1), .TIME_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .step(step), .threshold(threshold),
        .clear_total(clear_total), .sec_tick(sec_tick), .steps_per_sec(steps_per_sec),
        .active(active), .streak_secs(streak_secs), .high_activity_min(high_activity_min)
    );

    activity_level_timer #(.SEC_DIV(48), .CNT_W(4), .SUSTAIN(3), .GRACE(1), .TIME_W(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .step(step_b), .threshold(threshold_b),
        .clear_total(clear_b), .sec_tick(tick_b), .steps_per_sec(spc_b),
        .active(active_b), .streak_secs(streak_b), .high_activity_min(min_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_streak = 0; m_gap = 0; m_min = 0; m_spc = 0;
    endtask

    // One closed second: 0 IDLE, 1 ACTIVE, 2 PAUSE.
    task automatic model_sec(input int n, input bit clr);
        exp_t e;
        bit hi;
        m_spc = (n > 15) ? 15 : n;
        hi = (m_spc >= int'(threshold));
        if (hi) begin
            m_state = 1;
            m_gap = 0;
            if (m_streak + 1 == 3) begin
                m_streak = 0;
                if (m_min < 15) m_min++;
            end else begin
                m_streak++;
            end
        end else if (m_state == 1) begin
            m_state = 2;
            m_gap = 1;
        end else if (m_state == 2) begin
            m_gap++;
            if (m_gap > 1) begin
                m_state = 0; m_streak = 0; m_gap = 0;
            end
        end
        if (clr) m_min = 0;
        e.spc = m_spc; e.act = (m_state != 0); e.strk = m_streak; e.mins = m_min;
        sb.push_back(e);
    endtask

    // Drive one aligned window: n pulses on even cycles, optional clear in the tick cycle.
    task automatic win(input int n, input bit clr);
        model_sec(n, clr);
        for (int i = 0; i < 10; i++) begin
            step = (i % 2 == 0) && (i / 2 < n);
            clear_total = clr && (i == 9);
            if (i == 9) check("tick_pos", sec_tick, 1);
            @(negedge clk);
        end
        step = 1'b0;
        clear_total = 1'b0;
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        if (sec_tick === 1'b1) begin
            @(negedge clk);
            n_tick++;
            check($sformatf("t%0d_expected", n_tick), sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("t%0d_spc", n_tick), steps_per_sec, e.spc);
                check($sformatf("t%0d_active", n_tick), active, e.act);
                check($sformatf("t%0d_streak", n_tick), streak_secs, e.strk);
                check($sformatf("t%0d_min", n_tick), high_activity_min, e.mins);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t held;
        reset = 1'b1; enable = 1'b0; step = 1'b0; step_b = 1'b0;
        clear_total = 1'b0; threshold = 4'd2;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_tick", sec_tick, 0);
        check("rst_spc", steps_per_sec, 0);
        check("rst_active", active, 0);
        check("rst_streak", streak_secs, 0);
        check("rst_min", high_activity_min, 0);
        reset = 1'b0;

        // 20 pulses in one long window on dut_b; main DUT disabled sees the same pulses.
        for (int i = 0; i < 48; i++) begin
            step_b = (i < 40) && (i % 2 == 0);
            step   = step_b;
            if (i == 47) check("b_tick", tick_b, 1);
            @(negedge clk);
        end
        step_b = 1'b0; step = 1'b0;
        check("b_spc_sat", spc_b, 15);
        check("dis_spc", steps_per_sec, 0);
        check("dis_active", active, 0);

        enable = 1'b1;
        repeat (3) win(3, 0);
        win(3, 0); win(0, 0); win(3, 0); win(3, 0);
        win(3, 0); win(0, 0); win(0, 0);
        win(1, 0); win(2, 0);
        threshold = 4'd0;
        win(0, 0);
        threshold = 4'd2;
        win(3, 1);

        // Window split by a 25-cycle disable with pulses that must be ignored.
        held.spc = m_spc; held.act = (m_state != 0); held.strk = m_streak; held.mins = m_min;
        model_sec(2, 0);
        for (int i = 0; i < 5; i++) begin
            step = (i == 0);
            @(negedge clk);
        end
        enable = 1'b0;
        for (int j = 0; j < 25; j++) begin
            step = (j < 20) && (j % 2 == 0);
            @(negedge clk);
        end
        check("hold_spc", steps_per_sec, held.spc);
        check("hold_active", active, held.act);
        check("hold_streak", streak_secs, held.strk);
        check("hold_min", high_activity_min, held.mins);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step = (i == 0);
            if (i == 4) check("resume_tick", sec_tick, 1);
            @(negedge clk);
        end
        step = 1'b0;

        repeat (54) win(3, 0);

        win(3, 1); win(3, 0); win(3, 0); win(3, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_tick", sec_tick, 0);
        check("arst_spc", steps_per_sec, 0);
        check("arst_active", active, 0);
        check("arst_streak", streak_secs, 0);
        check("arst_min", high_activity_min, 0);
        model_reset();
        step = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Step held high across release must not count; first window is a full one.
        model_sec(0, 0);
        for (int i = 0; i < 10; i++) begin
            step = (i != 9);
            if (i == 9) check("post_rst_tick", sec_tick, 1);
            @(negedge clk);
        end
        win(3, 0);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/activity_level_timer.md
ACTIVITY_LEVEL_TIMER -- requirements
Module: activity_level_timer

Interface
REQ-001 SHALL have parameter SEC_DIV, default 50_000_000, clk cycles per one-second window (>=4).
REQ-002 SHALL have parameter CNT_W, default 8, width of per-second step count and threshold.
REQ-003 SHALL have parameter SUSTAIN, default 60, consecutive high seconds per credited minute (>=1).
REQ-004 SHALL have parameter GRACE, default 2, low seconds tolerated inside a streak (>=0).
REQ-005 SHALL have parameter TIME_W, default 12, width of high-activity minute total.
REQ-006 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-007 SHALL have port enable input 1: counting active when high.
REQ-008 SHALL have port step input 1: raw step pulse, asynchronous to clk.
REQ-009 SHALL have port threshold input CNT_W: minimum steps per second for a high second.
REQ-010 SHALL have port clear_total input 1: synchronous clear of minute total.
REQ-011 SHALL have port sec_tick output 1: one-cycle pulse at each window close.
REQ-012 SHALL have port steps_per_sec output CNT_W: step count of last closed window.
REQ-013 SHALL have port active output 1: high while FSM is in ACTIVE or PAUSE.
REQ-014 SHALL have port streak_secs output $clog2(SUSTAIN+1): high seconds in current streak.
REQ-015 SHALL have port high_activity_min output TIME_W: total credited minutes.

Function
REQ-016 step SHALL pass a 2-flop synchronizer; a step event = rising edge of synchronized signal (0->1), 3-cycle input-to-event latency.
REQ-017 Prescaler SHALL count 0..SEC_DIV-1 while enable=1, wrap to 0; sec_tick=1 in the cycle prescaler==SEC_DIV-1.
REQ-018 Window counter SHALL increment per step event, saturating at 2^CNT_W-1; event in the tick cycle counts toward the closing window.
REQ-019 On tick: steps_per_sec <= window count (incl. same-cycle event); window counter <= 0.
REQ-020 Second is high iff closed count >= threshold (threshold=0 -> every second high).
REQ-021 FSM states IDLE, ACTIVE, PAUSE; transitions only on sec_tick.
REQ-022 IDLE: high -> ACTIVE, streak=1; low -> stay, streak=0.
REQ-023 ACTIVE: high -> streak+1; low -> PAUSE, gap=1 if GRACE>0, else IDLE, streak=0.
REQ-024 PAUSE: high -> ACTIVE, streak+1, gap=0; low -> gap+1; if new gap > GRACE -> IDLE, streak=0, gap=0.
REQ-025 When streak increment reaches SUSTAIN: high_activity_min+1 (saturate at 2^TIME_W-1), streak <= 0, state stays ACTIVE.
REQ-026 Low seconds in PAUSE SHALL NOT add to streak.
REQ-027 enable=0: prescaler, window counter, FSM, streak, gap hold; step events ignored; sec_tick=0; outputs hold.
REQ-028 clear_total=1: high_activity_min <= 0 next edge, overriding a same-cycle credit; streak/FSM unaffected.
REQ-029 Threshold change SHALL take effect at the next sec_tick evaluation, no retiming.

Reset
REQ-030 reset=1 SHALL asynchronously force: prescaler, window counter, gap, streak, steps_per_sec, high_activity_min = 0; sec_tick=0; active=0; FSM=IDLE; synchronizer flops=0.
REQ-031 Reset mid-window SHALL discard partial window; first window after release is full SEC_DIV cycles.
REQ-032 Step pulse held high across reset release SHALL NOT produce an event until it falls and rises again.

Verification (SEC_DIV=10, CNT_W=4, SUSTAIN=3, GRACE=1, TIME_W=4, threshold=2)
REQ-033 3 steps per window for 3 windows -> steps_per_sec=3 each tick; streak 1,2,0; high_activity_min=1; active=1.
REQ-034 Windows high,low,high,high -> PAUSE after 2nd, streak stays 1; credit at 4th tick (min=1, streak=0).
REQ-035 Windows high,low,low -> IDLE at 3rd tick, streak=0, active=0, min=0.
REQ-036 20 steps in one window -> steps_per_sec saturates at 15; 18 credited minutes -> min saturates at 15.
REQ-037 clear_total in same cycle as credit tick -> min=0; enable=0 for 25 cycles with steps -> no tick, counts unchanged.
REQ-038 reset asserted mid-streak (streak=2, min=1) -> all outputs 0 and IDLE immediately, no clk edge needed.
